// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard front end: pin conditioning, frame receiver, scan-code
// decoder and a runtime-programmable key map driving a held-key bitmap.
module ps2_key_matrix #(
  parameter int NUM_KEYS = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter logic [NUM_KEYS*9-1:0] DEFAULT_MAP = '0,
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [8:0]          cfg_code,
  output logic [NUM_KEYS-1:0] kb_key_pressed,
  output logic [NUM_KEYS-1:0] key_press_tick,
  output logic [NUM_KEYS-1:0] key_release_tick,
  output logic                rx_valid,
  output logic [7:0]          rx_byte,
  output logic                frame_err
);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

  // synchroniser and debounce state
  logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic              filt_q, filt_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              fall_q, fall_d;
  logic              bit_q, bit_d;

  // receiver state
  rx_state_t         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              frame_err_q, frame_err_d;

  // decoder and key map state
  logic              ext_q, ext_d, brk_q, brk_d;
  logic [8:0]        map_q [NUM_KEYS];
  logic [8:0]        map_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] bm_q, bm_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] clr_mask;

  // Two-flop synchronisers, reset to the idle-high bus level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Debounce: flip the filtered clock after FILTER_LEN differing samples; a fall latches data.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall_d     = 1'b0;
    bit_d      = bit_q;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        if (filt_q) begin
          fall_d = 1'b1;
          bit_d  = dat_s2_q;
        end
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Debounce registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
      bit_q      <= 1'b1;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
      bit_q      <= bit_d;
    end
  end

  // Frame receiver: start, 8 data LSB first, odd parity, stop, plus inter-edge timeout.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    to_cnt_d    = to_cnt_q;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte_q;
    frame_err_d = 1'b0;
    if (fall_q) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (bit_q) begin
            frame_err_d = 1'b1;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = bit_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (bit_q && (^{shift_q, par_q})) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_err_d = 1'b1;
        state_d     = ST_IDLE;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Receiver registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      rx_valid_q  <= rx_valid_d;
      rx_byte_q   <= rx_byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Scan-code decoder and key map update; a cfg write silently clears its bit and wins collisions.
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    bm_d     = bm_q;
    clr_mask = '0;
    match    = '0;
    map_d    = map_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (map_q[i] == {ext_q, rx_byte_q});
    end
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid_q) begin
      case (rx_byte_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'h00, 8'hFF: begin
          bm_d  = '0;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        8'hAA, 8'hFA, 8'hFE, 8'hEE: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          if (brk_q) bm_d = bm_q & ~match;
          else       bm_d = bm_q | match;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
    if (cfg_we && (int'(cfg_idx) < NUM_KEYS)) begin
      map_d[cfg_idx]    = cfg_code;
      clr_mask[cfg_idx] = 1'b1;
    end
    bm_d      = bm_d & ~clr_mask;
    press_d   = bm_d & ~bm_q;
    release_d = bm_q & ~bm_d & ~clr_mask;
  end

  // Decoder, bitmap, tick and key map registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      bm_q      <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        map_q[i] <= DEFAULT_MAP[9*i +: 9];
      end
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      bm_q      <= bm_d;
      press_q   <= press_d;
      release_q <= release_d;
      map_q     <= map_d;
    end
  end

  assign kb_key_pressed   = bm_q;
  assign key_press_tick   = press_q;
  assign key_release_tick = release_q;
  assign rx_valid         = rx_valid_q;
  assign rx_byte          = rx_byte_q;
  assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Self-checking bench for ps2_key_matrix: table vectors, hand-written corner
// sequences and randomized frames against a behavioural key model.
module tb_ps2_key_matrix;

   localparam int NK = 8;
   localparam int FL = 4;
   localparam int TO = 2000;
   localparam int HALF = 12;
   localparam logic [NK*9-1:0] DMAP = {36'd0, 9'h172, 9'h175, 9'h01B, 9'h01D};

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ps2_clk = 1'b1;
   logic          ps2_data = 1'b1;
   logic          cfg_we = 1'b0;
   logic [2:0]    cfg_idx = '0;
   logic [8:0]    cfg_code = '0;
   logic [NK-1:0] kb_key_pressed, key_press_tick, key_release_tick;
   logic          rx_valid, frame_err;
   logic [7:0]    rx_byte;

   ps2_key_matrix #(
      .NUM_KEYS(NK), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .DEFAULT_MAP(DMAP)
   ) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
      .kb_key_pressed(kb_key_pressed), .key_press_tick(key_press_tick),
      .key_release_tick(key_release_tick), .rx_valid(rx_valid),
      .rx_byte(rx_byte), .frame_err(frame_err)
   );

   // 100 MHz system clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Event tallies taken on the falling edge, away from the active edge
   int press_tot = 0, rel_tot = 0, valid_tot = 0, err_tot = 0;
   bit dual_rel = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         press_tot += $countones(key_press_tick);
         rel_tot   += $countones(key_release_tick);
         valid_tot += int'(rx_valid);
         err_tot   += int'(frame_err);
         if ($countones(key_release_tick) >= 2) dual_rel = 1'b1;
      end
   end

   // Behavioural model: key map, held set, prefix flags and expected event totals
   logic [8:0]    km [NK];
   logic [NK-1:0] m_bm;
   bit            m_ext, m_brk;
   int            m_press = 0, m_rel = 0, m_valid = 0, m_err = 0;
   logic [7:0]    m_last;

   task automatic modelReset();
      for (int i = 0; i < NK; i++) km[i] = DMAP[9*i +: 9];
      m_bm = '0; m_ext = 0; m_brk = 0; m_last = 8'h00;
   endtask

   task automatic modelByte(input logic [7:0] b, input bit bad);
      if (bad) begin
         m_err++; m_ext = 0; m_brk = 0;
      end else begin
         m_valid++; m_last = b;
         if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else begin
            if (b == 8'h00 || b == 8'hFF) begin
               m_rel += $countones(m_bm); m_bm = '0;
            end else if (!(b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE)) begin
               for (int i = 0; i < NK; i++) begin
                  if (km[i] == {m_ext, b}) begin
                     if (m_brk && m_bm[i]) begin m_rel++; m_bm[i] = 1'b0; end
                     if (!m_brk && !m_bm[i]) begin m_press++; m_bm[i] = 1'b1; end
                  end
               end
            end
            m_ext = 0; m_brk = 0;
         end
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive the first nbits of one PS/2 frame; data changes while the clock is high
   task automatic applyStimulus(input logic [7:0] b, input bit bad, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad, b, 1'b0};
      for (int k = 0; k < nbits; k++) begin
         ps2_data = fr[k];
         waitCycles(HALF);
         ps2_clk = 1'b0;
         waitCycles(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      waitCycles(HALF);
   endtask

   task automatic sendByte(input logic [7:0] b, input bit bad);
      applyStimulus(b, bad, 11);
      modelByte(b, bad);
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, "_bitmap"}, 32'(kb_key_pressed), 32'(m_bm));
      checkOutput({tag, "_press"}, press_tot, m_press);
      checkOutput({tag, "_release"}, rel_tot, m_rel);
      checkOutput({tag, "_valid"}, valid_tot, m_valid);
      checkOutput({tag, "_err"}, err_tot, m_err);
      checkOutput({tag, "_rxbyte"}, 32'(rx_byte), 32'(m_last));
   endtask

   typedef struct {
      logic [7:0] code;
      bit         bad;
      logic [7:0] exp_map;
      int         exp_press;
      int         exp_rel;
      int         exp_err;
   } vec_t;

   vec_t tbl [18];

   initial begin
      tbl[0]  = '{8'h1D, 1'b0, 8'h01, 1, 0, 0};
      tbl[1]  = '{8'hF0, 1'b0, 8'h01, 1, 0, 0};
      tbl[2]  = '{8'h1D, 1'b0, 8'h00, 1, 1, 0};
      tbl[3]  = '{8'hE0, 1'b0, 8'h00, 1, 1, 0};
      tbl[4]  = '{8'h75, 1'b0, 8'h04, 2, 1, 0};
      tbl[5]  = '{8'h75, 1'b0, 8'h04, 2, 1, 0};
      tbl[6]  = '{8'hE0, 1'b0, 8'h04, 2, 1, 0};
      tbl[7]  = '{8'hF0, 1'b0, 8'h04, 2, 1, 0};
      tbl[8]  = '{8'h75, 1'b0, 8'h00, 2, 2, 0};
      tbl[9]  = '{8'h1D, 1'b0, 8'h01, 3, 2, 0};
      tbl[10] = '{8'h1D, 1'b0, 8'h01, 3, 2, 0};
      tbl[11] = '{8'h1D, 1'b0, 8'h01, 3, 2, 0};
      tbl[12] = '{8'h1D, 1'b1, 8'h01, 3, 2, 1};
      tbl[13] = '{8'h1B, 1'b0, 8'h03, 4, 2, 1};
      tbl[14] = '{8'hFF, 1'b0, 8'h00, 4, 4, 1};
      tbl[15] = '{8'hF0, 1'b0, 8'h00, 4, 4, 1};
      tbl[16] = '{8'h1D, 1'b1, 8'h00, 4, 4, 2};
      tbl[17] = '{8'h1D, 1'b0, 8'h01, 5, 4, 2};

      modelReset();
      waitCycles(5);
      checkOutput("reset_bitmap", 32'(kb_key_pressed), 32'h0);
      checkOutput("reset_ticks", 32'({key_press_tick, key_release_tick}), 32'h0);
      checkOutput("reset_rx", 32'({rx_valid, frame_err, rx_byte}), 32'h0);
      reset = 1'b0;
      waitCycles(5);

      // Table: make/break, extended codes, typematic, bad parity, overrun
      for (int v = 0; v < 18; v++) begin
         sendByte(tbl[v].code, tbl[v].bad);
         checkOutput($sformatf("tbl%0d_bitmap", v), 32'(kb_key_pressed), 32'(tbl[v].exp_map));
         checkOutput($sformatf("tbl%0d_press", v), press_tot, tbl[v].exp_press);
         checkOutput($sformatf("tbl%0d_release", v), rel_tot, tbl[v].exp_rel);
         checkOutput($sformatf("tbl%0d_err", v), err_tot, tbl[v].exp_err);
         if (!tbl[v].bad) checkOutput($sformatf("tbl%0d_rxbyte", v), 32'(rx_byte), 32'(tbl[v].code));
         if (v == 14) checkOutput("overrun_same_cycle_release", 32'(dual_rel), 32'h1);
      end

      // Timeout: start plus 4 data bits, then silence
      applyStimulus(8'h1B, 1'b0, 5);
      checkOutput("timeout_not_early", err_tot, 2);
      waitCycles(TO + 40);
      m_err++; m_ext = 0; m_brk = 0;
      checkOutput("timeout_err", err_tot, 3);
      checkModel("timeout");
      sendByte(8'h1B, 1'b0);
      checkOutput("after_timeout_bitmap", 32'(kb_key_pressed), 32'h03);
      checkModel("after_timeout");

      // Remap entry 0 to 0x1C: bit0 clears silently
      cfg_we = 1'b1; cfg_idx = 3'd0; cfg_code = 9'h01C;
      waitCycles(1);
      cfg_we = 1'b0;
      km[0] = 9'h01C; m_bm[0] = 1'b0;
      waitCycles(2);
      checkOutput("cfg_clear_bitmap", 32'(kb_key_pressed), 32'h02);
      checkOutput("cfg_no_release", rel_tot, 4);
      sendByte(8'h1C, 1'b0);
      checkOutput("cfg_new_code", 32'(kb_key_pressed), 32'h03);
      sendByte(8'hF0, 1'b0);
      sendByte(8'h1D, 1'b0);
      checkOutput("cfg_old_code_ignored", 32'(kb_key_pressed), 32'h03);
      checkModel("cfg");

      // Randomized frames against the model
      for (int r = 0; r < 40; r++) begin
         logic [7:0] b;
         case ($urandom_range(0, 10))
            0: b = 8'h1D;  1: b = 8'h1B;  2: b = 8'h1C;  3: b = 8'h75;
            4: b = 8'h72;  5: b = 8'hF0;  6: b = 8'hE0;  7: b = 8'hF0;
            8: b = 8'hE0;  9: b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'hAA;
            default: b = 8'($urandom);
         endcase
         sendByte(b, $urandom_range(0, 9) == 0);
         checkModel($sformatf("rnd%0d", r));
      end

      // Reset mid-frame discards the partial frame and restores the map
      applyStimulus(8'h1C, 1'b0, 4);
      reset = 1'b1;
      waitCycles(3);
      checkOutput("midreset_bitmap", 32'(kb_key_pressed), 32'h0);
      checkOutput("midreset_ticks", 32'({key_press_tick, key_release_tick}), 32'h0);
      checkOutput("midreset_rx", 32'({rx_valid, frame_err, rx_byte}), 32'h0);
      reset = 1'b0;
      modelReset();
      waitCycles(3);
      sendByte(8'h1D, 1'b0);
      checkOutput("post_reset_default_map", 32'(kb_key_pressed), 32'h01);
      checkModel("post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
